// File: rtl/rs_decode_sched_pkg.sv
// Shared types for the RS decode job scheduler: FSM states, result record and timer sizing.
package rs_decode_sched_pkg;

  localparam int DEF_WORD_W    = 32;
  localparam int DEF_NUM_WORDS = 50;
  localparam int RES_CW_W      = DEF_WORD_W * DEF_NUM_WORDS;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    STORE
  } state_t;

  typedef struct packed {
    logic [RES_CW_W-1:0] pos;
    logic                err;
    logic                fail;
    logic                timeout;
  } res_t;

  // Timer only has to reach TIMEOUT-1; keep at least one bit for tiny timeouts.
  function automatic int tmr_w(input int t);
    return (t <= 2) ? 1 : $clog2(t);
  endfunction

endpackage

// File: rtl/rs_decode_res_fifo.sv
// Show-ahead result FIFO; push to head visible in 1 cycle.
// A push is accepted when full only if a pop lands in the same cycle; a pop on empty is dropped.
module rs_decode_res_fifo
  import rs_decode_sched_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_vld,
  input  res_t             push_dat,
  input  logic             pop_rdy,
  output res_t             head_dat,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  res_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o  = (count_o == '0);
  assign full_o   = (count_o == CNT_W'(DEPTH));
  assign do_pop   = pop_rdy && !empty_o;
  assign do_push  = push_vld && (!full_o || do_pop);
  // Head reads as zero when empty so the result outputs are clean after reset/flush.
  assign head_dat = empty_o ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem[wr_ptr] <= push_dat;
    end
  end

endmodule

// File: rtl/rs_decode_sched.sv
// Job scheduler between register file and RS core: start->req 1 cycle, done->result 2 cycles.
// start_i is refused (sticky overflow) unless IDLE with room for its result; core_req_o holds until ack.
module rs_decode_sched
  import rs_decode_sched_pkg::*;
#(
  parameter int  WORD_W    = DEF_WORD_W,
  parameter int  NUM_WORDS = DEF_NUM_WORDS,
  parameter int  RES_DEPTH = 2,
  parameter int  TIMEOUT   = 1024,
  parameter int  CNT_W     = 16,
  localparam int CW_W      = WORD_W * NUM_WORDS,
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              in_wr_i,
  input  logic [IDX_W-1:0]  in_idx_i,
  input  logic [WORD_W-1:0] in_wdata_i,
  input  logic              start_i,
  output logic              core_req_o,
  output logic [CW_W-1:0]   core_cw_o,
  input  logic              core_ack_i,
  input  logic              core_done_i,
  input  logic              core_err_i,
  input  logic              core_fail_i,
  input  logic [CW_W-1:0]   core_pos_i,
  output logic              res_valid_o,
  input  logic              res_pop_i,
  output logic [CW_W-1:0]   res_pos_o,
  output logic              res_err_o,
  output logic              res_fail_o,
  output logic              res_timeout_o,
  output logic              busy_o,
  output logic              ready_o,
  output logic              overflow_o,
  input  logic              irq_en_i,
  output logic              irq_o,
  output logic [CNT_W-1:0]  cnt_ok_o,
  output logic [CNT_W-1:0]  cnt_err_o,
  output logic [CNT_W-1:0]  cnt_fail_o
);

  localparam int               TMR_W    = tmr_w(TIMEOUT);
  localparam int               FCNT_W   = $clog2(RES_DEPTH + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [CW_W-1:0]   stage_q;
  res_t              cap;
  res_t              head;
  logic [FCNT_W-1:0] fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  int                occ;

  // The in-flight job holds a FIFO slot in reserve so STORE can never find it full.
  always_comb begin
    occ     = int'(fifo_count) + int'(state != IDLE);
    ready_o = (state == IDLE) && (occ < RES_DEPTH);
  end

  assign busy_o = (state != IDLE);
  assign push   = (state == STORE) && !clear_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      stage_q <= '0;
    end else if (in_wr_i && (int'(in_idx_i) < NUM_WORDS)) begin
      stage_q[int'(in_idx_i)*WORD_W +: WORD_W] <= in_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      core_req_o <= 1'b0;
      core_cw_o  <= '0;
      timer      <= '0;
      cap        <= '0;
    end else if (clear_i) begin
      state      <= IDLE;
      core_req_o <= 1'b0;
      timer      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && ready_o) begin
            core_cw_o  <= stage_q;
            core_req_o <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (core_ack_i) begin
            core_req_o <= 1'b0;
            timer      <= '0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          timer <= timer + 1'b1;
          if (core_done_i) begin
            cap   <= '{pos: core_pos_i, err: core_err_i, fail: core_fail_i, timeout: 1'b0};
            state <= STORE;
          end else if (timer == TMR_LAST) begin
            cap   <= '{pos: '0, err: 1'b0, fail: 1'b1, timeout: 1'b1};
            state <= STORE;
          end
        end
        STORE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Fail (timeouts included) takes precedence over a corrected error.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_ok_o   <= '0;
      cnt_err_o  <= '0;
      cnt_fail_o <= '0;
    end else if (state == STORE) begin
      if (cap.fail) begin
        if (!(&cnt_fail_o)) cnt_fail_o <= cnt_fail_o + 1'b1;
      end else if (cap.err) begin
        if (!(&cnt_err_o)) cnt_err_o <= cnt_err_o + 1'b1;
      end else begin
        if (!(&cnt_ok_o)) cnt_ok_o <= cnt_ok_o + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      overflow_o <= 1'b0;
    end else if (start_i && !ready_o) begin
      overflow_o <= 1'b1;
    end
  end

  rs_decode_res_fifo #(
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (clear_i),
    .push_vld (push),
    .push_dat (cap),
    .pop_rdy  (res_pop_i),
    .head_dat (head),
    .count_o  (fifo_count),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign res_valid_o   = !fifo_empty;
  assign res_pos_o     = head.pos;
  assign res_err_o     = head.err;
  assign res_fail_o    = head.fail;
  assign res_timeout_o = head.timeout;
  assign irq_o         = res_valid_o && irq_en_i;

endmodule

// File: tb/tb_rs_decode_sched.sv
// Directed bench for rs_decode_sched; results checked through a scoreboard as they are popped.
module tb_rs_decode_sched;
  import rs_decode_sched_pkg::*;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 50;
  localparam int RES_DEPTH = 2;
  localparam int TIMEOUT   = 1024;
  localparam int CNT_W     = 16;
  localparam int CW_W      = WORD_W * NUM_WORDS;
  localparam int IDX_W     = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, clear, in_wr, start, core_ack, core_done, core_err, core_fail, res_pop, irq_en;
  logic [IDX_W-1:0]  in_idx;
  logic [WORD_W-1:0] in_wdata;
  logic [CW_W-1:0]   core_pos;

  logic              core_req, res_valid, res_err, res_fail, res_timeout, busy, ready, overflow, irq;
  logic [CW_W-1:0]   core_cw, res_pos;
  logic [CNT_W-1:0]  cnt_ok, cnt_err, cnt_fail;

  logic              s_core_req, s_res_valid, s_res_err, s_res_fail, s_res_timeout;
  logic              s_busy, s_ready, s_overflow, s_irq;
  logic [CW_W-1:0]   s_core_cw, s_res_pos;
  logic [1:0]        s_cnt_ok, s_cnt_err, s_cnt_fail;

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t exp_q[$];
  res_t mon_e;

  rs_decode_sched #(
    .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .RES_DEPTH(RES_DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_wr_i(in_wr), .in_idx_i(in_idx),
    .in_wdata_i(in_wdata), .start_i(start), .core_req_o(core_req), .core_cw_o(core_cw),
    .core_ack_i(core_ack), .core_done_i(core_done), .core_err_i(core_err), .core_fail_i(core_fail),
    .core_pos_i(core_pos), .res_valid_o(res_valid), .res_pop_i(res_pop), .res_pos_o(res_pos),
    .res_err_o(res_err), .res_fail_o(res_fail), .res_timeout_o(res_timeout), .busy_o(busy),
    .ready_o(ready), .overflow_o(overflow), .irq_en_i(irq_en), .irq_o(irq),
    .cnt_ok_o(cnt_ok), .cnt_err_o(cnt_err), .cnt_fail_o(cnt_fail)
  );

  // Same stimulus with 2-bit counters so saturation is reachable in a short run.
  rs_decode_sched #(
    .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .RES_DEPTH(RES_DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(2)
  ) dut_sat (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .in_wr_i(in_wr), .in_idx_i(in_idx),
    .in_wdata_i(in_wdata), .start_i(start), .core_req_o(s_core_req), .core_cw_o(s_core_cw),
    .core_ack_i(core_ack), .core_done_i(core_done), .core_err_i(core_err), .core_fail_i(core_fail),
    .core_pos_i(core_pos), .res_valid_o(s_res_valid), .res_pop_i(res_pop), .res_pos_o(s_res_pos),
    .res_err_o(s_res_err), .res_fail_o(s_res_fail), .res_timeout_o(s_res_timeout), .busy_o(s_busy),
    .ready_o(s_ready), .overflow_o(s_overflow), .irq_en_i(irq_en), .irq_o(s_irq),
    .cnt_ok_o(s_cnt_ok), .cnt_err_o(s_cnt_err), .cnt_fail_o(s_cnt_fail)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    res_pop = 1'b1;
    step();
    res_pop = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!core_req && n < 16) begin
      step();
      n++;
    end
    check("req_seen", core_req, 1);
  endtask

  task automatic run_job(input int ack_dly, input int done_dly, input logic err, input logic fail,
                         input int pos_bit);
    logic [CW_W-1:0] p;
    p = '0;
    p[pos_bit] = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_req();
    repeat (ack_dly) step();
    core_ack = 1'b1;
    step();
    core_ack = 1'b0;
    repeat (done_dly - 1) step();
    core_done = 1'b1; core_err = err; core_fail = fail; core_pos = p;
    exp_q.push_back('{pos: p, err: err, fail: fail, timeout: 1'b0});
    step();
    core_done = 1'b0; core_err = 1'b0; core_fail = 1'b0; core_pos = '0;
    step();
  endtask

  // Scoreboard monitor: every accepted pop is compared with the oldest expected result.
  always @(negedge clk) begin
    if (!rst && res_pop && res_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got err=%0b fail=%0b tmo=%0b, expected no result",
                 res_err, res_fail, res_timeout);
      end else begin
        mon_e = exp_q.pop_front();
        if (res_pos !== mon_e.pos || res_err !== mon_e.err || res_fail !== mon_e.fail ||
            res_timeout !== mon_e.timeout) begin
          n_fail++;
          $display("FAIL result_check: got err=%0b fail=%0b tmo=%0b pos_match=%0b, expected err=%0b fail=%0b tmo=%0b",
                   res_err, res_fail, res_timeout, (res_pos === mon_e.pos),
                   mon_e.err, mon_e.fail, mon_e.timeout);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CW_W-1:0] exp_cw;
    int n;
    rst = 1'b1; clear = 1'b0; in_wr = 1'b0; in_idx = '0; in_wdata = '0; start = 1'b0;
    core_ack = 1'b0; core_done = 1'b0; core_err = 1'b0; core_fail = 1'b0; core_pos = '0;
    res_pop = 1'b0; irq_en = 1'b1;
    step();
    step();
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_req", core_req, 0);
    check("rst_valid", res_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_irq", irq, 0);
    check("rst_cnt", {cnt_ok, cnt_err, cnt_fail}, 0);
    check("rst_cw_zero", (core_cw == '0), 1);
    rst = 1'b0;

    // Full codeword, ack after 3 cycles, done 10 cycles later with a corrected error.
    for (int i = 0; i < NUM_WORDS; i++) begin
      in_wr = 1'b1; in_idx = IDX_W'(i); in_wdata = 32'h1000 + i;
      step();
    end
    in_wr = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("req_latency", core_req, 1);
    check("busy_in_req", busy, 1);
    check("ready_busy", ready, 0);
    for (int i = 0; i < NUM_WORDS; i++) check("cw_word", core_cw[i*WORD_W +: WORD_W], 32'h1000 + i);
    step();
    step();
    check("req_held", core_req, 1);
    core_ack = 1'b1;
    step();
    core_ack = 1'b0;
    check("req_drop_after_ack", core_req, 0);
    repeat (9) step();
    core_done = 1'b1; core_err = 1'b1; core_pos = '0; core_pos[5] = 1'b1;
    exp_q.push_back('{pos: core_pos, err: 1'b1, fail: 1'b0, timeout: 1'b0});
    step();
    core_done = 1'b0; core_err = 1'b0; core_pos = '0;
    check("valid_1cyc_after_done", res_valid, 0);
    step();
    check("valid_2cyc_after_done", res_valid, 1);
    check("pos_bit5", res_pos[5], 1);
    check("cnt_err_1", cnt_err, 1);
    check("irq_on", irq, 1);
    irq_en = 1'b0;
    #1;
    check("irq_masked", irq, 0);
    irq_en = 1'b1;
    pop_one();

    // Two results left in a depth-2 FIFO block the next start.
    run_job(1, 4, 1'b0, 1'b0, 7);
    run_job(0, 2, 1'b0, 1'b0, 9);
    check("full_ready", ready, 0);
    check("sat_cnt_ok_2", s_cnt_ok, 2);
    start = 1'b1;
    step();
    start = 1'b0;
    check("rejected_no_req", core_req, 0);
    check("rejected_not_busy", busy, 0);
    check("overflow_set", overflow, 1);
    pop_one();
    check("ready_after_pop", ready, 1);
    pop_one();
    check("overflow_sticky", overflow, 1);
    check("cnt_ok_2", cnt_ok, 2);

    // Core acks but never finishes.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    core_ack = 1'b1;
    step();
    core_ack = 1'b0;
    exp_q.push_back('{pos: '0, err: 1'b0, fail: 1'b1, timeout: 1'b1});
    n = 0;
    while (!res_valid && n < TIMEOUT + 10) begin
      step();
      n++;
    end
    check("timeout_latency", n, TIMEOUT + 1);
    check("timeout_flag", res_timeout, 1);
    check("cnt_fail_1", cnt_fail, 1);
    pop_one();

    // Done arrives in the same cycle the timer expires: done wins.
    start = 1'b1;
    step();
    start = 1'b0;
    core_ack = 1'b1;
    step();
    core_ack = 1'b0;
    repeat (TIMEOUT - 1) step();
    core_done = 1'b1; core_pos = '0; core_pos[3] = 1'b1;
    exp_q.push_back('{pos: core_pos, err: 1'b0, fail: 1'b0, timeout: 1'b0});
    step();
    core_done = 1'b0; core_pos = '0;
    step();
    check("race_valid", res_valid, 1);
    check("race_no_timeout", res_timeout, 0);
    check("cnt_ok_3", cnt_ok, 3);
    check("cnt_fail_still_1", cnt_fail, 1);
    pop_one();

    // clear_i during WAIT with one result queued.
    run_job(0, 3, 1'b0, 1'b0, 1);
    check("cnt_ok_4", cnt_ok, 4);
    check("sat_cnt_ok_saturated", s_cnt_ok, 3);
    start = 1'b1;
    step();
    start = 1'b0;
    core_ack = 1'b1;
    step();
    core_ack = 1'b0;
    step();
    step();
    check("busy_in_wait", busy, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    exp_q.delete();
    check("clr_busy", busy, 0);
    check("clr_valid", res_valid, 0);
    check("clr_cnt", {cnt_ok, cnt_err, cnt_fail}, 0);
    check("clr_sat_cnt", s_cnt_ok, 0);
    check("clr_overflow", overflow, 0);
    check("clr_ready", ready, 1);
    core_done = 1'b1; core_err = 1'b1;
    step();
    core_done = 1'b0; core_err = 1'b0;
    step();
    step();
    check("late_done_ignored", res_valid, 0);
    check("late_done_no_count", cnt_err, 0);

    // Staging after clear, out-of-range index, writes and done while a job is pending.
    in_wr = 1'b1;
    in_idx = 6'd0;  in_wdata = 32'hA5A5_0001; step();
    in_idx = 6'd49; in_wdata = 32'h1234_5678; step();
    in_idx = 6'd50; in_wdata = 32'hDEAD_BEEF; step();
    in_idx = 6'd63; in_wdata = 32'hCAFE_F00D; step();
    in_wr = 1'b0;
    exp_cw = '0;
    exp_cw[31:0] = 32'hA5A5_0001;
    exp_cw[49*WORD_W +: WORD_W] = 32'h1234_5678;
    start = 1'b1;
    step();
    start = 1'b0;
    check("cw_w0", core_cw[31:0], 32'hA5A5_0001);
    check("cw_w49", core_cw[49*WORD_W +: WORD_W], 32'h1234_5678);
    check("cw_w1_cleared", core_cw[WORD_W +: WORD_W], 0);
    check("cw_whole", (core_cw === exp_cw), 1);
    in_wr = 1'b1; in_idx = 6'd1; in_wdata = 32'hFFFF_FFFF; core_done = 1'b1;
    step();
    in_wr = 1'b0; core_done = 1'b0;
    check("cw_undisturbed", (core_cw === exp_cw), 1);
    check("done_in_req_ignored", core_req, 1);
    check("done_in_req_busy", busy, 1);
    core_ack = 1'b1;
    step();
    core_ack = 1'b0;
    step();
    core_done = 1'b1; core_pos = '0; core_pos[0] = 1'b1;
    exp_q.push_back('{pos: core_pos, err: 1'b0, fail: 1'b0, timeout: 1'b0});
    step();
    core_done = 1'b0; core_pos = '0;
    step();
    check("final_valid", res_valid, 1);
    check("final_cnt_ok", cnt_ok, 1);
    check("final_sat_cnt_ok", s_cnt_ok, 1);
    pop_one();
    step();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
